axi_sync_arbiter: RTL and testbench

Round-robin scheduler that shares the emulator's single AXI master port among all per-bank emulation-cache sync requesters, one per bank (`N = BANKGROUPS*BANKSPERGROUP`, index `bg*BANKSPERGROUP + ba`). Each granted request becomes one fixed-length INCR burst: an AW/W/B sequence for a write-back, or an AR/R sequence for a fill. The block sits between the cache sync logic of the DIMM model and the board-memory AXI interconnect. It handles one transaction at a time and reports completion and error per requester.

---
 rtl/axi_sync_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axi_sync_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sync_arbiter.sv
// rtl/axi_sync_arbiter.sv - round-robin arbiter sharing one AXI master among per-bank cache sync requesters
module axi_sync_arbiter #(
    parameter int BANKGROUPS     = 4,
    parameter int BANKSPERGROUP  = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int BURST_LEN      = 8,
    localparam int N  = BANKGROUPS * BANKSPERGROUP,
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N-1:0]                req,
    input  logic [N-1:0]                req_wr,
    input  logic [N*AXI_ADDR_WIDTH-1:0] req_addr,
    output logic [N-1:0]                gnt,
    output logic                        busy,
    output logic [BW-1:0]               beat,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_valid,
    output logic [N-1:0]                done,
    output logic [N-1:0]                err,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arcache,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                    state, state_n;
    logic [PW-1:0]             ptr, idx, sel;
    logic                      found;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic                      err_r;
    logic [N-1:0]              idx_oh;
    logic                      unused_rid;

    assign unused_rid = ^m_axi_rid;

    // First pending requester at or after ptr, wrapping.
    always_comb begin
        int j;
        sel   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                sel   = PW'(j);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (found) state_n = req_wr[sel] ? S_AW : S_AR;
            S_AW:   if (m_axi_awready) state_n = S_W;
            S_W:    if (m_axi_wready && beat == LAST) state_n = S_B;
            S_B:    if (m_axi_bvalid) state_n = S_DONE;
            S_AR:   if (m_axi_arready) state_n = S_R;
            S_R:    if (m_axi_rvalid && (beat == LAST || m_axi_rlast)) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            idx    <= '0;
            addr_q <= '0;
            beat   <= '0;
            err_r  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (found) begin
                    idx    <= sel;
                    addr_q <= req_addr[int'(sel)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    ptr    <= (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
                end
                S_W: if (m_axi_wready) beat <= beat + 1'b1;
                S_B: if (m_axi_bvalid && (m_axi_bresp != 2'b00 || m_axi_bid != AXI_ID_WIDTH'(idx)))
                    err_r <= 1'b1;
                S_R: if (m_axi_rvalid) begin
                    beat <= beat + 1'b1;
                    // A short or overlong burst is flagged, not recovered.
                    if (m_axi_rresp != 2'b00 || m_axi_rlast != (beat == LAST)) err_r <= 1'b1;
                end
                S_DONE: begin
                    beat  <= '0;
                    err_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign idx_oh   = N'(1) << idx;
    assign busy     = (state != S_IDLE);
    assign gnt      = busy ? idx_oh : '0;
    assign done     = (state == S_DONE) ? idx_oh : '0;
    assign err      = (state == S_DONE && err_r) ? idx_oh : '0;
    assign rd_data  = m_axi_rdata;
    assign rd_valid = (state == S_R) && m_axi_rvalid;

    assign m_axi_awid    = AXI_ID_WIDTH'(idx);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awvalid = (state == S_AW);
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state == S_W) && (beat == LAST);
    assign m_axi_wvalid  = (state == S_W);
    assign m_axi_bready  = (state == S_B);
    assign m_axi_arid    = AXI_ID_WIDTH'(idx);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = (state == S_AR);
    assign m_axi_rready  = (state == S_R);

endmodule

// File: tb/tb_axi_sync_arbiter.sv
// tb/tb_axi_sync_arbiter.sv - scoreboard bench for axi_sync_arbiter with N=16, BURST_LEN=4
module tb_axi_sync_arbiter;
    localparam int N = 16, L = 4, AW = 16, DW = 32, IW = 8, BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic [N-1:0] req, req_wr, gnt, done, err;
    logic [N*AW-1:0] req_addr;
    logic busy, rd_valid;
    logic [BW-1:0] beat;
    logic [DW-1:0] wr_data, rd_data;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [3:0] awcache, arcache, wstrb;
    logic [DW-1:0] wdata, rdata;

    axi_sync_arbiter #(.BURST_LEN(L)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .gnt(gnt), .busy(busy), .beat(beat), .wr_data(wr_data), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .err(err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int vectors = 0, miscompares = 0;
    logic [DW-1:0] exp_q[$];

    task automatic idle_slave();
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    endtask

    task automatic test_reset();
        reset = 1; req = 0; req_wr = 0; req_addr = 0; wr_data = 0;
        idle_slave();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({busy, gnt, done, err, rd_valid, beat, awvalid, wvalid, bready, arvalid, rready, wlast} !== '0
            || awaddr !== '0 || awid !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b gnt=%h done=%h awv=%b wv=%b arv=%b awaddr=%h, required all 0",
                     busy, gnt, done, awvalid, wvalid, arvalid, awaddr);
        end
        vectors++;
        if ({awlen, awsize, awburst, wstrb, arlen, arsize, arburst} !== {8'd3, 3'd2, 2'b01, 4'hF, 8'd3, 3'd2, 2'b01}) begin
            miscompares++;
            $display("FAIL reset_constants: awlen=%0d awsize=%0d awburst=%b wstrb=%h, required 3 2 01 f",
                     awlen, awsize, awburst, wstrb);
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic run_write(input int id, input logic [AW-1:0] addr, input int nstall,
                             input logic [1:0] bresp_v, input bit exp_err, input string name);
        int k, stalls, c;
        bit fin;
        logic [DW-1:0] pat, e;
        logic [N-1:0] oh;
        oh = '0; oh[id] = 1'b1;
        pat = {8'hD0 + 8'(id), 8'h00, addr};
        k = 0; stalls = 0; fin = 0;
        for (int b = 0; b < L; b++) exp_q.push_back(pat + DW'(b));
        @(negedge clk);
        req[id] = 1; req_wr[id] = 1; req_addr[id*AW +: AW] = addr;
        for (c = 1; c <= 40 && !fin; c++) begin
            @(negedge clk);
            awready = 1; bvalid = 1; bresp = bresp_v; bid = IW'(id);
            wready = !(k == 2 && stalls < nstall);
            wr_data = pat + DW'(beat);
            #1;
            if (awvalid) begin
                vectors++;
                if (c != 1 || awaddr !== addr || awid !== IW'(id) || awlen !== 8'd3 || gnt !== oh) begin
                    miscompares++;
                    $display("FAIL %s_aw: cyc=%0d awaddr=%h awid=%0d awlen=%0d gnt=%h, required cyc=1 %h %0d 3 %h",
                             name, c, awaddr, awid, awlen, gnt, addr, id, oh);
                end
            end
            if (wvalid && !wready) begin
                stalls++;
                vectors++;
                if (wdata !== pat + 2 || wlast !== 1'b0 || beat !== 2'd2) begin
                    miscompares++;
                    $display("FAIL %s_wstall: wdata=%h wlast=%b beat=%0d, required %h 0 2", name, wdata, wlast, beat, pat + 2);
                end
            end else if (wvalid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s_wextra: unexpected beat wdata=%h, required no beat", name, wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (wdata !== e || beat !== BW'(k) || wlast !== (k == L - 1) || c != k + 2 + stalls) begin
                        miscompares++;
                        $display("FAIL %s_wbeat%0d: wdata=%h beat=%0d wlast=%b cyc=%0d, required %h %0d %b %0d",
                                 name, k, wdata, beat, wlast, c, e, k, (k == L - 1), k + 2 + stalls);
                    end
                end
                k++;
            end
            if (done !== '0) begin
                fin = 1;
                vectors++;
                if (done !== oh || err !== (exp_err ? oh : '0) || gnt !== oh || c != L + 3 + nstall || k != L) begin
                    miscompares++;
                    $display("FAIL %s_done: done=%h err=%h gnt=%h cyc=%0d beats=%0d, required %h %h %h %0d %0d",
                             name, done, err, gnt, c, k, oh, (exp_err ? oh : '0), oh, L + 3 + nstall, L);
                end
                req[id] = 0;
            end
        end
        if (!fin) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: done=0 after 40 cycles, required done pulse", name);
            req[id] = 0;
        end
        exp_q.delete();
        idle_slave();
    endtask

    task automatic run_read(input int id, input logic [AW-1:0] addr, input int rlast_beat, input string name);
        int rk, c, nbeats;
        bit fin, exp_err;
        logic [DW-1:0] e;
        logic [N-1:0] oh;
        oh = '0; oh[id] = 1'b1;
        nbeats = (rlast_beat < L - 1) ? rlast_beat + 1 : L;
        exp_err = (rlast_beat != L - 1);
        for (int b = 0; b < nbeats; b++) exp_q.push_back(32'hA0 + DW'(b));
        rk = 0; fin = 0;
        @(negedge clk);
        req[id] = 1; req_wr[id] = 0; req_addr[id*AW +: AW] = addr;
        for (c = 1; c <= 40 && !fin; c++) begin
            @(negedge clk);
            arready = 1; rvalid = 1; rresp = 0;
            rdata = 32'hA0 + DW'(rk); rlast = (rk == rlast_beat);
            #1;
            if (arvalid) begin
                vectors++;
                if (c != 1 || araddr !== addr || arid !== IW'(id) || arlen !== 8'd3 || gnt !== oh) begin
                    miscompares++;
                    $display("FAIL %s_ar: cyc=%0d araddr=%h arid=%0d arlen=%0d gnt=%h, required cyc=1 %h %0d 3 %h",
                             name, c, araddr, arid, arlen, gnt, addr, id, oh);
                end
            end
            if (rd_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s_rextra: rd_valid beyond burst, rd_data=%h, required no beat", name, rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e || beat !== BW'(rk)) begin
                        miscompares++;
                        $display("FAIL %s_rbeat%0d: rd_data=%h beat=%0d, required %h %0d", name, rk, rd_data, beat, e, rk);
                    end
                end
                rk++;
            end
            if (done !== '0) begin
                fin = 1;
                vectors++;
                if (done !== oh || err !== (exp_err ? oh : '0) || c != nbeats + 2 || rk != nbeats) begin
                    miscompares++;
                    $display("FAIL %s_done: done=%h err=%h cyc=%0d beats=%0d, required %h %h %0d %0d",
                             name, done, err, c, rk, oh, (exp_err ? oh : '0), nbeats + 2, nbeats);
                end
                req[id] = 0;
            end
        end
        if (!fin) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: done=0 after 40 cycles, required done pulse", name);
            req[id] = 0;
        end
        exp_q.delete();
        idle_slave();
    endtask

    task automatic test_round_robin();
        int order[$];
        int c, rk, grants, last_done, cur;
        bit fin;
        order = '{0, 3, 0, 3};
        rk = 0; grants = 0; last_done = 0; cur = 0; fin = 0;
        @(negedge clk);
        req[0] = 1; req[3] = 1; req_wr[0] = 0; req_wr[3] = 0;
        req_addr[0 +: AW] = 16'h0100; req_addr[3*AW +: AW] = 16'h0400;
        for (c = 1; c <= 80 && !fin; c++) begin
            @(negedge clk);
            arready = 1; rvalid = 1; rresp = 0; rdata = 32'h55; rlast = (rk == L - 1);
            #1;
            if (arvalid) begin
                vectors++;
                cur = (order.size() > 0) ? order.pop_front() : -1;
                if (int'(arid) != cur || (grants > 0 && c - last_done != 2)) begin
                    miscompares++;
                    $display("FAIL rr_grant%0d: arid=%0d gap=%0d, required %0d gap=2", grants, arid, c - last_done, cur);
                end
                grants++; rk = 0;
            end
            if (rd_valid) rk++;
            if (done !== '0) begin
                vectors++;
                if (done !== (N'(1) << cur) || err !== '0) begin
                    miscompares++;
                    $display("FAIL rr_done%0d: done=%h err=%h, required %h 0", grants, done, err, N'(1) << cur);
                end
                last_done = c;
                if (grants == 4) begin
                    req[0] = 0; req[3] = 0; fin = 1;
                end
            end
        end
        if (!fin) begin
            vectors++; miscompares++;
            $display("FAIL rr_timeout: grants=%0d, required 4", grants);
            req = 0;
        end
        idle_slave();
    endtask

    task automatic test_mid_burst_reset();
        int c;
        bit hit;
        hit = 0;
        @(negedge clk);
        req[7] = 1; req_wr[7] = 1; req_addr[7*AW +: AW] = 16'h7700;
        for (c = 1; c <= 20 && !hit; c++) begin
            @(negedge clk);
            awready = 1; wready = 1; bvalid = 1; wr_data = 32'h7;
            #1;
            if (wvalid && beat == 2'd1) begin
                reset = 1; hit = 1;
            end
        end
        if (!hit) begin
            vectors++; miscompares++;
            $display("FAIL rst_timeout: W beat 1 not seen, required within 20 cycles");
        end
        @(negedge clk);
        reset = 0; req[7] = 0;
        #1;
        vectors++;
        if ({busy, awvalid, wvalid, bready, arvalid, rready, rd_valid} !== '0 || gnt !== '0
            || done !== '0 || dut.ptr !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_burst: busy=%b awv=%b wv=%b gnt=%h done=%h ptr=%0d, required all 0",
                     busy, awvalid, wvalid, gnt, done, dut.ptr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (done !== '0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_no_done: done=%h busy=%b, required 0 0", done, busy);
            end
        end
        idle_slave();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        run_write(5, 16'h1200, 0, 2'b00, 0, "single_write");
        run_write(6, 16'h2200, 3, 2'b00, 0, "w_backpressure");
        run_write(9, 16'h3400, 0, 2'b10, 1, "write_error");
        run_write(10, 16'h3500, 0, 2'b00, 0, "after_error");
        run_read(11, 16'h4000, 3, "read_fill");
        run_read(12, 16'h4100, 1, "read_early_rlast");
        test_mid_burst_reset();
        run_read(2, 16'h5000, 3, "read_after_reset");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
